// File: rtl/mips_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_mdu : iterative 32-step multiply/divide unit holding HI/LO          |
// | Optional: MIPS_MDU_SIGNED_EN enables two's-complement MULT/DIV           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mips_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_div_top;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_result;

`ifdef MIPS_MDU_SIGNED_EN
  logic neg_res_q, neg_res_d;
  logic rem_neg_q, rem_neg_d;
  logic w_sign_op;

  assign w_sign_op = op[0];
  assign w_rs_mag  = (w_sign_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign w_rt_mag  = (w_sign_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
`else
  logic w_unused_op0;

  assign w_unused_op0 = op[0];
  assign w_rs_mag     = rs_data;
  assign w_rt_mag     = rt_data;
`endif

  // Shift-add: multiplier sits in the low half and drains out to the right.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign w_mul_step = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: partial remainder can briefly need WIDTH+1 bits.
  assign w_div_top  = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = (w_div_top >= {1'b0, opnd_q});
  assign w_div_diff = w_div_top[WIDTH-1:0] - opnd_q;
  assign w_div_step = w_div_ge ? {w_div_diff, acc_q[WIDTH-2:0], 1'b1}
                               : {w_div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // A zero divisor naturally leaves the dividend as remainder; only LO is forced.
  always_comb begin
    w_result = acc_q;
`ifdef MIPS_MDU_SIGNED_EN
    if (!is_div_q) begin
      if (neg_res_q) w_result = -acc_q;
    end else begin
      if (neg_res_q) w_result[WIDTH-1:0]       = -acc_q[WIDTH-1:0];
      if (rem_neg_q) w_result[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
    end
`endif
    if (div0_q) w_result[WIDTH-1:0] = {WIDTH{1'b1}};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MIPS_MDU_SIGNED_EN
    neg_res_d = neg_res_q;
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = S_CALC;
          busy_d   = 1'b1;
          cnt_d    = 5'd0;
          is_div_d = op[1];
          div0_d   = op[1] && (rt_data == {WIDTH{1'b0}});
          opnd_d   = op[1] ? w_rt_mag : w_rs_mag;
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? w_rs_mag : w_rt_mag)};
`ifdef MIPS_MDU_SIGNED_EN
          neg_res_d = w_sign_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          rem_neg_d = w_sign_op && rs_data[WIDTH-1];
`endif
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? w_div_step : w_mul_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FINISH;
      end
      S_FINISH: begin
        hi_d    = w_result[2*WIDTH-1:WIDTH];
        lo_d    = w_result[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= {2*WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MIPS_MDU_SIGNED_EN
      neg_res_q <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MIPS_MDU_SIGNED_EN
      neg_res_q <= neg_res_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_mdu : directed vector bench for mips_mdu                         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_mips_mdu;

`ifdef MIPS_MDU_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  mips_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rstb(rstb), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for done; n is cycles after the start edge, 0 on timeout.
  task automatic wait_done(output int n, output logic busy_ok);
    int k;
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    n = done ? k : 0;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    logic bok;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs_data = 32'hDEADBEEF; rt_data = 32'h0; op = 2'b00;
    wait_done(n, bok);
    check({name, "_latency"}, n, 33);
    check({name, "_busy_during"}, {31'b0, bok}, 32'd1);
    check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    @(negedge clk);
    check({name, "_done_width"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int ndone;
    logic bok;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, SGN ? 32'hFFFFFFFF : 32'h00000006, 32'hFFFFFFEB};
    vecs[2]  = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[3]  = '{2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF};
    vecs[4]  = '{2'b11, 32'hFFFFFFF9, 32'd2, SGN ? 32'hFFFFFFFF : 32'd1, SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC};
    vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, SGN ? 32'h0 : 32'h80000000, SGN ? 32'h80000000 : 32'h0};
    vecs[6]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[7]  = '{2'b10, 32'd0, 32'd5, 32'd0, 32'd0};
    vecs[8]  = '{2'b01, 32'h80000000, 32'd2, SGN ? 32'hFFFFFFFF : 32'd1, 32'h0};
    vecs[9]  = '{2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF};
    vecs[11] = '{2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 32'hFFFE0001};
    vecs[12] = '{2'b11, 32'd7, 32'hFFFFFFFE, SGN ? 32'd1 : 32'd7, SGN ? 32'hFFFFFFFD : 32'd0};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rstb = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);

    // MTHI then MTLO while idle
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'h12345678);
    lo_we = 1'b1; wdata = 32'h9ABCDEF0;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", lo, 32'h9ABCDEF0);
    check("mtlo_hi_kept", hi, 32'h12345678);

    // DIVU 100/7 with a stray start and MTHI attempt mid-CALC
    op = 2'b10; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD0000;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("busy_mthi_ignored", hi, 32'h12345678);
    ndone = 0;
    for (int k = 0; k < 70; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midcalc_start_ndone", ndone, 1);
    check("midcalc_hi", hi, 32'd2);
    check("midcalc_lo", lo, 32'd14);

    // MTHI and start on the same idle edge
    hi_we = 1'b1; wdata = 32'h00000055; op = 2'b00; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0;
    check("same_edge_hi", hi, 32'h55);
    check("same_edge_busy", {31'b0, busy}, 32'd1);
    wait_done(n, bok);
    check("same_edge_latency", n, 33);
    check("same_edge_res_hi", hi, 32'd0);
    check("same_edge_res_lo", lo, 32'd12);
    @(negedge clk);

    // start held high: second accept at E34, second done 67 cycles after E0
    op = 2'b00; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
    @(negedge clk);
    wait_done(n, bok);
    check("b2b_first", n, 33);
    check("b2b_busy_at_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("b2b_rearm_busy", {31'b0, busy}, 32'd1);
    wait_done(n, bok);
    start = 1'b0;
    check("b2b_second", n, 33);
    check("b2b_lo", lo, 32'd6);
    @(negedge clk);

    // Reset mid-operation
    op = 2'b00; rs_data = 32'd5; rt_data = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rstb = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    check("midrst_lo_kept", lo, 32'd0);
    hi_we = 1'b1; wdata = 32'h000000A5;
    @(negedge clk);
    hi_we = 1'b0;
    check("post_rst_mthi", hi, 32'h000000A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_mdu.md
# mips_mdu

Multi-cycle multiply/divide unit for `mips_core`'s execute stage. It services the R-type MULT, MULTU, DIV and DIVU instructions with an iterative 32-step datapath, and holds the architectural HI/LO registers. The core hands it operands through a start/busy/done handshake, reads HI/LO for MFHI/MFLO, and writes them for MTHI/MTLO.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported.
- `clk`  in  1  system clock; everything updates on the rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the operation in `op`; sampled only in IDLE.
- `op`  in  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `rs_data`  in  32  multiplicand or dividend.
- `rt_data`  in  32  multiplier or divisor.
- `hi_we`  in  1  MTHI write strobe; honoured only in IDLE.
- `lo_we`  in  1  MTLO write strobe; honoured only in IDLE.
- `wdata`  in  32  data for MTHI/MTLO.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO now hold the result.
- `hi`  out  32  HI register (product upper half, or remainder).
- `lo`  out  32  LO register (product lower half, or quotient).

## Operation
- FSM states:
  - IDLE: `start` moves to CALC.
  - CALC: a 5-bit counter runs 0..31; when it reaches 31, move to FINISH.
  - FINISH: commit the result, then return to IDLE.
- On leaving IDLE, latch the operand magnitudes, the result sign and the remainder sign.
  - Signed ops take the magnitudes of `rs_data` and `rt_data`.
  - Also latch a divide-by-zero flag, set when `rt_data == 0` and `op[1] == 1`.
- Multiply: shift-add over a 64-bit accumulator, one multiplier bit per CALC cycle.
- Divide: restoring divider, one quotient bit per CALC cycle; remainder in the upper 32 bits.
- Signed fixup, applied in FINISH:
  - Product is negated when the operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Arithmetic is modulo 2^32 per register. DIV of 0x80000000 by 0xFFFFFFFF gives `lo` = 0x80000000 and `hi` = 0.
- Divide by zero gives `hi` = `rs_data` (as latched) and `lo` = 0xFFFFFFFF. It takes the full normal latency.
- `start` while not in IDLE is ignored; the core stalls on `busy`.
- `hi_we`/`lo_we` outside IDLE are ignored.
- `hi_we`/`lo_we` and `start` on the same IDLE edge: the write happens on that edge and `start` is also accepted. The later result overwrites the written value.
- `hi`/`lo` change only on a commit, on MTHI/MTLO, or on reset.

## Timing
- Reset values: state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, counter 0.
- Reset mid-operation returns the block to the reset values above immediately; no partial result is committed.
- `start` sampled high at edge E0:
  - `busy` is high from E0 until E33.
  - CALC occupies edges E1..E32.
  - E33 is the FINISH edge: `hi`/`lo` are written, `done` goes high for exactly one cycle, `busy` falls.
- A new `start` is accepted at E34 at the earliest (back-to-back throughput: 34 cycles).
- Latency is fixed at 33 cycles regardless of operand values, including zero divisors.
- `busy` and `done` are registered outputs with no combinational path from the inputs.

## Configuration
- `MIPS_MDU_SIGNED_EN` defined:
  - MULT and DIV use two's-complement semantics, as described above.
- `MIPS_MDU_SIGNED_EN` not defined:
  - `op[0]` is ignored, so MULT behaves as MULTU and DIV as DIVU.
  - The sign-latching and fixup logic is not built.
  - Latency is unchanged.

## Test plan
- Reset, then MULTU with 0xFFFFFFFF and 0xFFFFFFFF -> 33 cycles after `start`: `done` pulses, `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- MULT with -3 and 7:
  - With the macro: `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
  - Without the macro: `hi` = 0x00000006, `lo` = 0xFFFFFFEB.
- DIV with -7 and 2 (macro on) -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Then DIVU with 7 and 0 -> `hi` = 0x00000007, `lo` = 0xFFFFFFFF.
- MTHI with 0x12345678, then MTLO with 0x9ABCDEF0 -> `hi`/`lo` update on the next edge.
  - Then `start` DIVU 100/7 with `start` pulsed again mid-CALC -> only one `done`, `lo` = 14, `hi` = 2.
- Start MULTU with 5 and 5, then pull `rstb` low at cycle 10 -> `busy` and `done` go to 0, `hi`/`lo` go to 0, and no `done` follows.
  - After reset release, `hi_we` with 0xA5 while idle -> `hi` = 0x000000A5.
